// File: rtl/sopc_bus_arbiter_pkg.sv
// Shared encodings for the SOPC memory-port arbiter.
//   arb_state_e : arbiter FSM state, encoding doubles as the grant_o value
//                 (00 idle, 01 fetch owns bus, 10 data owns bus)
//   RSTN_ENABLE : level of the active-low reset input when reset is asserted
//   arb_pick    : fixed data-over-fetch choice with the fetch starvation guard
package sopc_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_IF   = 2'b01,
    ARB_DM   = 2'b10
  } arb_state_e;

  localparam logic RSTN_ENABLE = 1'b0;

  // Data wins unless fetch is pending and has already waited too long.
  function automatic arb_state_e arb_pick(input logic dm_req,
                                          input logic if_req,
                                          input logic starve);
    arb_state_e pick;
    if (dm_req && !(if_req && starve)) begin
      pick = ARB_DM;
    end else if (if_req) begin
      pick = ARB_IF;
    end else begin
      pick = ARB_IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/sopc_bus_arbiter.sv
// Shares the single Wishbone-style memory port between the instruction-fetch
// master (read-only) and the data master (load/store).
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-low reset
//   if_req_i/if_addr_i  : fetch request (held until if_ack_o) and address
//   if_data_o/if_ack_o  : fetch read data and one-cycle completion pulse
//   stallreq_if_o       : fetch pending and not yet acknowledged
//   dm_req_i/dm_we_i/dm_sel_i/dm_addr_i/dm_data_i : data request and payload
//   dm_data_o/dm_ack_o  : load data and one-cycle completion pulse
//   stallreq_mem_o      : data access pending and not yet acknowledged
//   wb_*                : registered bus master side (cyc == stb)
//   bus_err_o           : one-cycle pulse when a bus cycle is aborted on timeout
//   grant_o             : registered bus owner (00 idle, 01 fetch, 10 data)
module sopc_bus_arbiter
  import sopc_bus_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_IF_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic [DW-1:0]   if_data_o,
  output logic            if_ack_o,
  output logic            stallreq_if_o,
  input  logic            dm_req_i,
  input  logic            dm_we_i,
  input  logic [DW/8-1:0] dm_sel_i,
  input  logic [AW-1:0]   dm_addr_i,
  input  logic [DW-1:0]   dm_data_i,
  output logic [DW-1:0]   dm_data_o,
  output logic            dm_ack_o,
  output logic            stallreq_mem_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  output logic            bus_err_o,
  output logic [1:0]      grant_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int WW = $clog2(MAX_IF_WAIT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_IF_WAIT);

  arb_state_e    state_r;
  arb_state_e    next_grant_s;
  logic          starve_s;
  logic          owner_req_s;
  logic [TW-1:0] tmo_cnt_r;
  logic [WW-1:0] wait_cnt_r;

  // Arbitration decision, owner request and stall requests.
  always_comb begin
    starve_s     = (wait_cnt_r == WAIT_MAX);
    next_grant_s = arb_pick(dm_req_i, if_req_i, starve_s);
    if (state_r == ARB_IF) begin
      owner_req_s = if_req_i;
    end else begin
      owner_req_s = dm_req_i;
    end
    // Stall requests are forced low while reset is held so every output is 0.
    if (rst == RSTN_ENABLE) begin
      stallreq_if_o  = 1'b0;
      stallreq_mem_o = 1'b0;
    end else begin
      stallreq_if_o  = if_req_i && !if_ack_o;
      stallreq_mem_o = dm_req_i && !dm_ack_o;
    end
  end

  // Arbiter FSM, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      state_r    <= ARB_IDLE;
      tmo_cnt_r  <= '0;
      wait_cnt_r <= '0;
      grant_o    <= 2'b00;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= '0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      if_data_o  <= '0;
      dm_data_o  <= '0;
      if_ack_o   <= 1'b0;
      dm_ack_o   <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      if_ack_o  <= 1'b0;
      dm_ack_o  <= 1'b0;
      bus_err_o <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          tmo_cnt_r <= '0;
          state_r   <= next_grant_s;
          grant_o   <= next_grant_s;
          case (next_grant_s)
            ARB_DM: begin
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= dm_we_i;
              wb_sel_o <= dm_sel_i;
              wb_adr_o <= dm_addr_i;
              wb_dat_o <= dm_data_i;
              // Count data grants that overtake a pending fetch.
              if (!if_req_i) begin
                wait_cnt_r <= '0;
              end else if (!starve_s) begin
                wait_cnt_r <= wait_cnt_r + WW'(1);
              end else begin
                wait_cnt_r <= wait_cnt_r;
              end
            end
            ARB_IF: begin
              wb_cyc_o   <= 1'b1;
              wb_stb_o   <= 1'b1;
              wb_we_o    <= 1'b0;
              wb_sel_o   <= '1;
              wb_adr_o   <= if_addr_i;
              wb_dat_o   <= '0;
              wait_cnt_r <= '0;
            end
            default: begin
              wait_cnt_r <= '0;
            end
          endcase
        end
        ARB_IF, ARB_DM: begin
          // A late ack in the expiry cycle still completes normally.
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state_r  <= ARB_IDLE;
            grant_o  <= 2'b00;
            // A master that withdrew its request (flush) gets no ack.
            if (owner_req_s) begin
              if (state_r == ARB_IF) begin
                if_ack_o  <= 1'b1;
                if_data_o <= wb_dat_i;
              end else begin
                dm_ack_o  <= 1'b1;
                dm_data_o <= wb_dat_i;
              end
            end else begin
              if_ack_o <= 1'b0;
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            state_r   <= ARB_IDLE;
            grant_o   <= 2'b00;
            bus_err_o <= 1'b1;
            if (owner_req_s) begin
              if (state_r == ARB_IF) begin
                if_ack_o  <= 1'b1;
                if_data_o <= '0;
              end else begin
                dm_ack_o  <= 1'b1;
                dm_data_o <= '0;
              end
            end else begin
              if_ack_o <= 1'b0;
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        default: begin
          state_r  <= ARB_IDLE;
          grant_o  <= 2'b00;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sopc_bus_arbiter.sv
// Directed self-checking bench for sopc_bus_arbiter with a simple
// registered-ack Wishbone slave (programmable wait states or no ack).
module tb_sopc_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_ack;
  logic        stallreq_if;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_sel;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        stallreq_mem;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack;
  logic        bus_err;
  logic [1:0]  grant;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // slave model controls
  int s_wait  = 0;
  bit s_never = 1'b0;
  int s_cnt;

  sopc_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data),
    .if_ack_o(if_ack), .stallreq_if_o(stallreq_if),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_sel_i(dm_sel),
    .dm_addr_i(dm_addr), .dm_data_i(dm_wdata), .dm_data_o(dm_rdata),
    .dm_ack_o(dm_ack), .stallreq_mem_o(stallreq_mem),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_sel_o(wb_sel), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack),
    .bus_err_o(bus_err), .grant_o(grant)
  );

  always #5 clk = ~clk;

  // Slave: ack registered s_wait cycles after the first cycle of cyc.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack <= 1'b0;
      s_cnt  <= 0;
    end else if (wb_cyc && !wb_ack && !s_never) begin
      if (s_cnt >= s_wait) begin
        wb_ack <= 1'b1;
        s_cnt  <= 0;
      end else begin
        s_cnt <= s_cnt + 1;
      end
    end else begin
      wb_ack <= 1'b0;
      if (!wb_cyc) s_cnt <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance until the selected ack pulses, at most budget cycles.
  task automatic run_until_ack(input bit want_if, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (want_if ? if_ack : dm_ack) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [1:0] owners [8];
    int         n_own;
    logic [1:0] prev_grant;
    bit         got;
    int         cyc_cycles;
    int         flush_acks;

    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_sel = '0; dm_addr = '0; dm_wdata = '0;
    wb_dat_i = 32'h0;
    #2;
    check("reset_cyc",   {63'd0, wb_cyc}, 64'd0);
    check("reset_grant", {62'd0, grant},  64'd0);
    tick(); tick();
    rst = 1'b1;

    // ---- fetch only, 0-wait slave ----
    tick();
    wb_dat_i = 32'h3402_0001;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    #1 check("t1_stall_c0", {63'd0, stallreq_if}, 64'd1);
    tick();                                             // c1
    check("t1_cyc_c1",   {62'd0, wb_cyc, wb_stb}, 64'h3);
    check("t1_adr_c1",   {32'd0, wb_adr}, 64'h100);
    check("t1_wesel_c1", {59'd0, wb_we, wb_sel}, 64'h0F);
    check("t1_grant_c1", {62'd0, grant}, 64'h1);
    tick();                                             // c2
    check("t1_ack_c2",   {62'd0, if_ack, stallreq_if}, 64'h1);
    tick();                                             // c3
    check("t1_ack_c3",   {61'd0, if_ack, stallreq_if, wb_cyc}, 64'h4);
    check("t1_data_c3",  {32'd0, if_data}, 64'h3402_0001);
    if_req = 1'b0;
    tick();
    check("t1_ack_c4",   {63'd0, if_ack}, 64'd0);

    // ---- simultaneous store and fetch: data first ----
    wb_dat_i = 32'h1111_2222;
    dm_req = 1'b1; dm_we = 1'b1; dm_sel = 4'b0011;
    dm_addr = 32'h0000_2000; dm_wdata = 32'h0000_55AA;
    if_req = 1'b1; if_addr = 32'h0000_0104;
    tick();                                             // c1
    check("t2_grant_dm", {62'd0, grant}, 64'h2);
    check("t2_wesel",    {59'd0, wb_we, wb_sel}, 64'h13);
    check("t2_adr_dat",  {wb_adr, wb_dat_o}, {32'h0000_2000, 32'h0000_55AA});
    tick(); tick();                                     // c3
    check("t2_dm_ack",   {61'd0, dm_ack, grant}, 64'h4);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();                                             // c4
    check("t2_grant_if", {62'd0, grant}, 64'h1);
    check("t2_if_bus",   {27'd0, wb_we, wb_sel, wb_adr}, {27'd0, 1'b0, 4'hF, 32'h0000_0104});
    tick(); tick();                                     // c6
    check("t2_if_ack",   {31'd0, if_ack, if_data}, {31'd0, 1'b1, 32'h1111_2222});
    if_req = 1'b0;
    tick();

    // ---- starvation guard: continuous data, fetch held ----
    dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h0000_3000;
    if_req = 1'b1; if_addr = 32'h0000_0108;
    n_own = 0; prev_grant = 2'b00; got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (grant != 2'b00 && prev_grant == 2'b00 && n_own < 8) begin
        owners[n_own] = grant;
        n_own++;
      end
      prev_grant = grant;
      if (if_ack) begin
        got = 1'b1;
        break;
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
    check("t3_if_served", {63'd0, got}, 64'd1);
    check("t3_n_grants",  64'(n_own), 64'd5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_owner%0d", i), {62'd0, owners[i]}, 64'h2);
    end
    check("t3_owner4", {62'd0, owners[4]}, 64'h1);
    tick();
    // wait counter was cleared by the fetch grant, so data wins again
    dm_req = 1'b1; if_req = 1'b1;
    tick();
    check("t3_cleared", {62'd0, grant}, 64'h2);
    run_until_ack(1'b0, 10, got);
    check("t3_dm_done", {63'd0, got}, 64'd1);
    dm_req = 1'b0;
    run_until_ack(1'b1, 10, got);
    check("t3_if_done", {63'd0, got}, 64'd1);
    if_req = 1'b0;
    tick();

    // ---- slave never acks: timeout abort ----
    s_never = 1'b1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_5000;
    tick();                                             // c1
    check("t4_cyc_c1", {63'd0, wb_cyc}, 64'd1);
    cyc_cycles = 0;
    for (int i = 0; i < 15; i++) begin
      tick();                                           // c2..c16
      if (wb_cyc && !dm_ack && !bus_err) cyc_cycles++;
    end
    check("t4_cyc_held", 64'(cyc_cycles), 64'd15);
    tick();                                             // c17
    check("t4_abort", {61'd0, wb_cyc, bus_err, dm_ack}, 64'h3);
    check("t4_data0", {32'd0, dm_rdata}, 64'd0);
    dm_req = 1'b0;
    s_never = 1'b0;
    tick();
    check("t4_err_pulse", {63'd0, bus_err}, 64'd0);
    wb_dat_i = 32'hCAFE_F00D;
    if_req = 1'b1; if_addr = 32'h0000_010C;
    tick(); tick(); tick();                             // c3
    check("t4_next_ok", {31'd0, if_ack, if_data}, {31'd0, 1'b1, 32'hCAFE_F00D});
    if_req = 1'b0;
    tick();

    // ---- fetch flushed mid-cycle, 3-wait slave ----
    s_wait = 3;
    wb_dat_i = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    tick();                                             // c1
    check("t5_cyc_c1", {63'd0, wb_cyc}, 64'd1);
    tick();                                             // c2
    if_req = 1'b0;
    flush_acks = 0;
    tick(); tick(); tick();                             // c5
    if (if_ack) flush_acks++;
    check("t5_slave_ack", {62'd0, wb_cyc, wb_ack}, 64'h3);
    tick();                                             // c6
    if (if_ack) flush_acks++;
    check("t5_done", {61'd0, wb_cyc, grant}, 64'd0);
    tick();
    if (if_ack) flush_acks++;
    check("t5_no_ack", 64'(flush_acks), 64'd0);
    check("t5_data_held", {32'd0, if_data}, 64'hCAFE_F00D);
    s_wait = 0;

    // ---- reset during a data cycle ----
    dm_req = 1'b1; dm_we = 1'b1; dm_sel = 4'hF;
    dm_addr = 32'h0000_6000; dm_wdata = 32'h1234_5678;
    tick();                                             // c1
    check("t6_grant_dm", {62'd0, grant}, 64'h2);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_ctl", {56'd0, wb_cyc, wb_stb, wb_we, dm_ack, if_ack, stallreq_mem, grant}, 64'd0);
    check("t6_rst_bus", {24'd0, bus_err, wb_sel, wb_adr, 3'd0}, 64'd0);
    check("t6_rst_data", {wb_dat_o, dm_rdata}, 64'd0);
    tick();
    check("t6_rst_hold", {62'd0, wb_cyc, dm_ack}, 64'd0);
    rst = 1'b1;                                         // c0'
    #1 check("t6_stall_c0", {63'd0, stallreq_mem}, 64'd1);
    tick();                                             // c1'
    check("t6_regrant", {61'd0, wb_cyc, grant}, 64'h6);
    tick();                                             // c2'
    check("t6_no_early_ack", {63'd0, dm_ack}, 64'd0);
    tick();                                             // c3'
    check("t6_ack_c3", {63'd0, dm_ack}, 64'd1);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
